// File: rtl/sap_pkg.sv
// Shared SAP definitions: opcodes, widths and W-bus source priority.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sap_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'h3,
        OP_HLT = 4'h4
    } opcode_e;

    // W-bus sources, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_PC   = 3'd1,
        SRC_RAM  = 3'd2,
        SRC_IR   = 3'd3,
        SRC_A    = 3'd4,
        SRC_ALU  = 3'd5
    } bus_src_e;

    // Fixed priority EP > CE > EI > EA > EU. CE and EI are active-low.
    function automatic bus_src_e bus_select(input logic ep, input logic ce_n,
                                            input logic ei_n, input logic ea,
                                            input logic eu);
        bus_src_e src;
        src = SRC_NONE;
        if (ep)         src = SRC_PC;
        else if (!ce_n) src = SRC_RAM;
        else if (!ei_n) src = SRC_IR;
        else if (ea)    src = SRC_A;
        else if (eu)    src = SRC_ALU;
        return src;
    endfunction

    // Number of bus sources requesting the bus this cycle.
    function automatic logic [2:0] bus_src_count(input logic ep, input logic ce_n,
                                                 input logic ei_n, input logic ea,
                                                 input logic eu);
        return {2'b00, ep} + {2'b00, ~ce_n} + {2'b00, ~ei_n}
             + {2'b00, ea} + {2'b00, eu};
    endfunction

endpackage

// File: rtl/sap_ram16x8.sv
// 16x8 program/data RAM: asynchronous read, synchronous write, no reset.
// Latency: read 0 cycles; a write becomes visible after the clock edge.
// Backpressure: none.
// Ports: clk, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port.
module sap_ram16x8
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       we_i,
    input  logic [3:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [3:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Read of the address being written returns the old content this cycle.
    assign rdata_o = mem_q[raddr_i];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

endmodule

// File: rtl/sap_datapath.sv
// SAP datapath: PC, MAR, RAM, IR, A, B, ALU, OUT around a shared 8-bit W-bus.
// Latency: register loads visible 1 cycle after the edge; out_valid 1 cycle after LO.
// Backpressure: none; control lines from the controller are obeyed every cycle.
// Ports: clk, reset (async active-low), twelve control lines CP..LO,
//        prog_we/prog_addr/prog_data RAM load port, IRData opcode to controller,
//        out_data/out_valid output register, bus_conflict diagnostic.
module sap_datapath
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       CP,
    input  logic       EP,
    input  logic       LM,
    input  logic       CE,
    input  logic       LI,
    input  logic       EI,
    input  logic       LA,
    input  logic       EA,
    input  logic       SU,
    input  logic       EU,
    input  logic       LB,
    input  logic       LO,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [3:0] IRData,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       bus_conflict
);

    logic [3:0] pc_q, pc_d;
    logic [3:0] mar_q, mar_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] out_q, out_d;
    logic       out_vld_q, out_vld_d;

    logic [7:0] ram_rdata;
    logic [7:0] alu_res;
    logic [7:0] bus;
    bus_src_e   bus_src;

    sap_ram16x8 u_ram (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (mar_q),
        .rdata_o (ram_rdata)
    );

    // Two's-complement subtract; carry out is dropped, no flags.
    assign alu_res = SU ? (a_q + ~b_q + 8'd1) : (a_q + b_q);

    always_comb begin
        bus_src = bus_select(EP, CE, EI, EA, EU);
        bus     = 8'h00;
        case (bus_src)
            SRC_PC:  bus = {4'h0, pc_q};
            SRC_RAM: bus = ram_rdata;
            SRC_IR:  bus = {4'h0, ir_q[3:0]};
            SRC_A:   bus = a_q;
            SRC_ALU: bus = alu_res;
            default: bus = 8'h00;
        endcase
    end

    assign bus_conflict = (bus_src_count(EP, CE, EI, EA, EU) > 3'd1);

    // Bypass lets the controller branch on the opcode in the same cycle IR loads.
    assign IRData = LI ? ir_q[7:4] : bus[7:4];

    always_comb begin
        pc_d      = CP ? (pc_q + 4'd1) : pc_q;
        mar_d     = LM ? mar_q : bus[3:0];
        ir_d      = LI ? ir_q  : bus;
        a_d       = LA ? a_q   : bus;
        b_d       = LB ? b_q   : bus;
        out_d     = LO ? out_q : bus;
        out_vld_d = ~LO;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q      <= 4'h0;
            mar_q     <= 4'h0;
            ir_q      <= 8'h00;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            out_q     <= 8'h00;
            out_vld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            mar_q     <= mar_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign out_data  = out_q;
    assign out_valid = out_vld_q;

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Datapath stage of the 8-bit SAP processor, directly downstream of the SAP controller. It consumes the controller's twelve control lines, and holds the program counter, MAR, 16x8 RAM, instruction register, accumulator, B register, add/subtract ALU, output register and the shared 8-bit W-bus. It returns the opcode nibble to the controller. A programming port loads RAM before or while the processor runs.

## Interface
- No parameters; widths are fixed (8-bit data, 4-bit address/opcode).
- clk  in  1  rising-edge clock, shared with the controller
- reset  in  1  asynchronous, active-low
- CP  in  1  active-high; PC increment
- EP  in  1  active-high; PC drives bus
- LM  in  1  active-low; MAR load from bus[3:0]
- CE  in  1  active-low; RAM[MAR] drives bus
- LI  in  1  active-low; IR load from bus
- EI  in  1  active-low; IR[3:0] drives bus
- LA  in  1  active-low; A load from bus
- EA  in  1  active-high; A drives bus
- SU  in  1  active-high; ALU subtracts (A-B) instead of adds
- EU  in  1  active-high; ALU drives bus
- LB  in  1  active-low; B load from bus
- LO  in  1  active-low; OUT load from bus
- prog_we  in  1  RAM write strobe, sampled at clk
- prog_addr  in  4  RAM write address
- prog_data  in  8  RAM write data
- IRData  out  4  opcode to controller
- out_data  out  8  output register
- out_valid  out  1  one-cycle pulse after OUT is loaded
- bus_conflict  out  1  more than one bus source enabled this cycle (combinational)

## Operation
- Bus sources: EP -> {4'h0,PC}; CE -> RAM[MAR]; EI -> {4'h0,IR[3:0]}; EA -> A; EU -> ALU.
- With no source enabled, bus = 8'h00.
- With multiple sources enabled, the fixed priority is EP > CE > EI > EA > EU, and bus_conflict=1.
- ALU is combinational: SU=0 gives A+B mod 256; SU=1 gives A+(~B)+1 mod 256. Carry is discarded and there are no flags.
- Register loads all occur at posedge clk, from the bus value of the cycle ending at that edge:
  - MAR <= bus[3:0]
  - IR <= bus
  - A <= bus
  - B <= bus
  - OUT <= bus
- PC: CP=1 gives PC <= PC+1 mod 16, so 15 wraps to 0. CP and EP in the same cycle is legal: the old PC is driven and PC increments.
- IRData bypass: while LI=0, IRData = bus[7:4]; otherwise IRData = IR[7:4]. This lets the controller's fetch-decode state branch on the opcode being loaded in that cycle.
- Opcodes: 0 LDA, 1 ADD, 2 SUB, 3 OUT, 4 HLT. The datapath does not decode them; they are only passed through.
- RAM:
  - Asynchronous read.
  - Synchronous write on prog_we.
  - A prog_we write to address MAR in the same cycle as CE=0 drives the old content; the new content is visible the next cycle.
  - RAM is not reset.
- out_valid = registered (LO==0).

## Timing
- Reset (reset=0, asynchronous):
  - PC, MAR, IR, A, B and OUT are cleared to 0.
  - out_valid = 0.
  - IRData = 0 unless LI=0; the controller holds LI=1 in its reset state.
  - RAM contents are retained.
- Reset mid-instruction aborts immediately. After release, execution restarts from PC=0 at the first rising edge.
- Load latency is 1 cycle: a register loaded at edge N is visible on the bus and outputs after edge N.
- ALU output reflects A/B changes combinationally in the same cycle they update.
- The control lines are glitch-free Moore outputs of the controller and need no synchronisation.
- Per-instruction cycles, as supplied by the controller:
  - Fetch: 3 cycles (EP/LM, CP, CE/LI).
  - LDA: +2 cycles.
  - ADD/SUB: +3 cycles.
  - OUT: +1 cycle.
- out_valid rises on the edge after the LO=0 cycle and lasts exactly 1 cycle per OUT.

## Structure
- Shared package sap_pkg holds:
  - opcode constants OP_LDA=0, OP_ADD=1, OP_SUB=2, OP_OUT=3, OP_HLT=4;
  - data width 8 and address width 4;
  - bus-source priority order.
- The controller and datapath both import sap_pkg.
- One sub-module, sap_ram16x8: asynchronous read, synchronous write port, no reset.
- Bus mux, ALU and registers stay inline in sap_datapath.

## Test plan
- Reset: preload RAM, pulse reset=0 mid-run -> PC/MAR/IR/A/B/OUT = 0, out_valid = 0, RAM unchanged.
- Full program with the controller attached:
  - Program: RAM[0..4] = 09,1A,2B,30,40; RAM[9]=10, RAM[A]=14, RAM[B]=18.
  - Required: out_data = 0x0C, a single out_valid pulse, then halt with PC = 5 held.
- Arithmetic wrap: A=F0, B=20 with SU=0, EU=1, LA=0 -> A=10. Then A=05, B=07 with SU=1 -> A=FE.
- IRData bypass: RAM[MAR]=0x3C with CE=0, LI=0 -> IRData=3 in that same cycle; IRData stays 3 after the edge once LI=1.
- PC wrap and bus conflict:
  - PC=F with CP=1 -> PC=0.
  - EP=1 and EA=1 together -> bus={0,PC}, bus_conflict=1.
  - No sources enabled -> bus=00.
- Programming collision: prog_we to address MAR=7 (old 0x11, new 0x22) with CE=0 -> bus=0x11 in that cycle, 0x22 in the next.
